// File: rtl/stack_datapath_p_if.sv
// Memory bus between the stack datapath and its memory.
//   mem_req   : request, held high until ack or timeout (master -> slave)
//   mem_we    : 1 = write request (master -> slave)
//   mem_addr  : address, taken from MAR (master -> slave)
//   mem_wdata : write data, taken from MDR (master -> slave)
//   mem_rdata : read data, valid together with mem_ack (slave -> master)
//   mem_ack   : transaction completion (slave -> master)
interface stack_datapath_p_if #(
  parameter int unsigned DW = 16
) ();
  logic          mem_req;
  logic          mem_we;
  logic [DW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/stack_datapath_p.sv
// Multi-cycle datapath for the stack CPU: PC, SP, MAR, MDR, IR, T, flags and a GPR bank around
// an OR-ed X bus, a T-driven Y operand and an ALU Z bus. Owns a req/ack memory handshake FSM with
// timeout; while a transaction is in flight busy is high and all load enables are ignored.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   ld[8:0]             : load enables 0 R,1 PC,2 SP,3 F,4 T,5 MAR,6 MDR (7,8 reserved)
//   tr[5:0]             : X-bus drivers 0 R,1 PC,2 SP,3 MAR,4 MDR,5 label
//   alop[2:0]           : ALU operation
//   mem_rd, mem_wr      : start a read / write (sampled only when idle)
//   rd_to_ir            : read data goes to IR instead of MDR
//   mem                 : memory bus (master side)
//   busy                : transaction in flight
//   instr               : IR contents
//   status              : flags[instr[14:13]] ^ instr[12]
//   sp_fault, mem_err   : sticky error flags
module stack_datapath_p #(
  parameter int unsigned   DW       = 16,
  parameter int unsigned   NREG     = 8,
  parameter int unsigned   LW       = 12,
  parameter logic [DW-1:0] SP_RESET = 'hFFFF,
  parameter logic [DW-1:0] SP_BASE  = 'hFFFF,
  parameter logic [DW-1:0] SP_LIMIT = 'hF000,
  parameter int unsigned   TIMEOUT  = 15
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [8:0]                ld,
  input  logic [5:0]                tr,
  input  logic [2:0]                alop,
  input  logic                      mem_rd,
  input  logic                      mem_wr,
  input  logic                      rd_to_ir,
  stack_datapath_p_if.master        mem,
  output logic                      busy,
  output logic [DW-1:0]             instr,
  output logic                      status,
  output logic                      sp_fault,
  output logic                      mem_err
);

  localparam int unsigned IW = $clog2(NREG);
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [0:0] {StIdle, StReq} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            we_q, we_d;
  logic            to_ir_q, to_ir_d;
  logic            rd_done, timeout;

  logic [DW-1:0]   pc_q, sp_q, mar_q, mdr_q, ir_q, t_q;
  logic [3:0]      flags_q, flags_d;
  logic [DW-1:0]   gpr_q [NREG];
  logic            sp_fault_q, mem_err_q;

  logic [IW-1:0]   idx;
  logic [DW-1:0]   label, x, y, z;
  logic [DW:0]     sum, dif, inc;
  logic            c, v, sp_ok;
  logic [6:0]      ld_en;
  logic            unused_ld;

  assign unused_ld = ^ld[8:7];

  assign idx   = ir_q[4 +: IW];
  assign label = {{(DW-LW){ir_q[LW-1]}}, ir_q[LW-1:0]};
  assign y     = t_q;
  assign busy  = (state_q == StReq);
  // Everything except FSM-owned MDR/IR is frozen while a transaction runs.
  assign ld_en = busy ? 7'd0 : ld[6:0];

  // X bus: OR of every enabled source.
  always_comb begin
    x = '0;
    if (tr[0]) x = x | gpr_q[idx];
    if (tr[1]) x = x | pc_q;
    if (tr[2]) x = x | sp_q;
    if (tr[3]) x = x | mar_q;
    if (tr[4]) x = x | mdr_q;
    if (tr[5]) x = x | label;
  end

  // ALU. C on subtract means "no borrow", i.e. Y >= X unsigned.
  always_comb begin
    sum = {1'b0, x} + {1'b0, y};
    dif = {1'b0, y} - {1'b0, x};
    inc = {1'b0, x} + {{DW{1'b0}}, 1'b1};
    z   = '0;
    c   = 1'b0;
    v   = 1'b0;
    case (alop)
      3'd0: begin
        z = sum[DW-1:0];
        c = sum[DW];
        v = (x[DW-1] == y[DW-1]) && (z[DW-1] != x[DW-1]);
      end
      3'd1: begin
        z = dif[DW-1:0];
        c = ~dif[DW];
        v = (y[DW-1] != x[DW-1]) && (z[DW-1] != y[DW-1]);
      end
      3'd2: z = x & y;
      3'd3: z = x | y;
      3'd4: z = x ^ y;
      3'd5: z = ~x;
      3'd6: z = x;
      default: begin
        z = inc[DW-1:0];
        c = inc[DW];
        v = ~x[DW-1] & z[DW-1];
      end
    endcase
    flags_d = {v, c, z[DW-1], (z == '0)};
  end

  assign sp_ok = (z >= SP_LIMIT) && (z <= SP_BASE);

  // Memory handshake FSM next state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    to_ir_d = to_ir_q;
    rd_done = 1'b0;
    timeout = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (mem_rd || mem_wr) begin
          state_d = StReq;
          cnt_d   = '0;
          we_d    = mem_wr;
          to_ir_d = rd_to_ir & ~mem_wr;
        end
      end
      StReq: begin
        if (mem.mem_ack) begin
          state_d = StIdle;
          rd_done = ~we_q;
        end else if (cnt_q == CW'(TIMEOUT)) begin
          state_d = StIdle;
          timeout = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      to_ir_q    <= 1'b0;
      pc_q       <= '0;
      sp_q       <= SP_RESET;
      mar_q      <= '0;
      mdr_q      <= '0;
      ir_q       <= '0;
      t_q        <= '0;
      flags_q    <= '0;
      sp_fault_q <= 1'b0;
      mem_err_q  <= 1'b0;
      for (int i = 0; i < NREG; i++) gpr_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      to_ir_q <= to_ir_d;
      if (ld_en[0]) gpr_q[idx] <= z;
      if (ld_en[1]) pc_q <= z;
      if (ld_en[2]) begin
        if (sp_ok) sp_q <= z;
        else       sp_fault_q <= 1'b1;
      end
      if (ld_en[3]) flags_q <= flags_d;
      if (ld_en[4]) t_q <= x;
      if (ld_en[5]) mar_q <= z;
      if (rd_done && !to_ir_q) mdr_q <= mem.mem_rdata;
      else if (ld_en[6])       mdr_q <= z;
      if (rd_done && to_ir_q) ir_q <= mem.mem_rdata;
      if (timeout) mem_err_q <= 1'b1;
    end
  end

  assign mem.mem_req   = busy;
  assign mem.mem_we    = busy & we_q;
  assign mem.mem_addr  = mar_q;
  assign mem.mem_wdata = mdr_q;
  assign instr         = ir_q;
  assign status        = flags_q[ir_q[14:13]] ^ ir_q[12];
  assign sp_fault      = sp_fault_q;
  assign mem_err       = mem_err_q;

endmodule

// File: tb/tb_stack_datapath_p.sv
// Directed bench for stack_datapath_p: table of ALU vectors plus hand sequences for the memory
// handshake, SP window, timeout and reset-during-request cases.
module tb_stack_datapath_p;

  localparam logic [8:0] LD_R = 9'h001, LD_PC = 9'h002, LD_SP = 9'h004, LD_F = 9'h008;
  localparam logic [8:0] LD_T = 9'h010, LD_MAR = 9'h020;
  localparam logic [5:0] TR_R = 6'h01, TR_PC = 6'h02, TR_SP = 6'h04, TR_MDR = 6'h10;
  localparam logic [5:0] TR_LBL = 6'h20;

  logic        clk = 1'b0;
  logic        reset;
  logic [8:0]  ld;
  logic [5:0]  tr;
  logic [2:0]  alop;
  logic        mem_rd, mem_wr, rd_to_ir;
  logic        busy, status, sp_fault, mem_err;
  logic [15:0] instr;

  stack_datapath_p_if #(.DW(16)) m ();

  stack_datapath_p dut (
    .clk      (clk),
    .reset    (reset),
    .ld       (ld),
    .tr       (tr),
    .alop     (alop),
    .mem_rd   (mem_rd),
    .mem_wr   (mem_wr),
    .rd_to_ir (rd_to_ir),
    .mem      (m.master),
    .busy     (busy),
    .instr    (instr),
    .status   (status),
    .sp_fault (sp_fault),
    .mem_err  (mem_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] x;
    logic [15:0] t;
    logic [2:0]  op;
    logic [15:0] z;
    logic [3:0]  f;  // {V, C, N, Z}
  } alu_vec_t;

  alu_vec_t    vecs [12];
  int          n_cmp = 0;
  int          n_err = 0;
  int          nb;
  logic        we_seen;
  logic [15:0] val;
  logic [3:0]  fl;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One cycle of control inputs, starting and ending on a falling edge.
  task automatic cyc(input logic [8:0] l, input logic [5:0] t, input logic [2:0] a);
    ld = l; tr = t; alop = a;
    @(negedge clk);
    ld = '0; tr = '0; alop = '0;
  endtask

  // Runs one memory transaction; ack arrives in busy cycle ack_at (0 = never).
  task automatic mem_txn(input logic rd, input logic wr, input logic to_ir, input logic [15:0] d,
                         input int ack_at, input logic poke, output int nbusy,
                         output logic we_first);
    mem_rd = rd; mem_wr = wr; rd_to_ir = to_ir;
    @(negedge clk);
    mem_rd = 1'b0; mem_wr = 1'b0; rd_to_ir = 1'b0;
    nbusy    = 0;
    we_first = m.mem_we;
    while (busy && nbusy < 64) begin
      nbusy++;
      if (nbusy == ack_at) begin
        m.mem_ack   = 1'b1;
        m.mem_rdata = d;
      end
      if (poke) begin
        ld = '1; tr = '1; alop = 3'd7;
      end
      @(negedge clk);
      m.mem_ack = 1'b0;
    end
    ld = '0; tr = '0; alop = '0;
  endtask

  task automatic rd_mem(input logic [15:0] d, input logic to_ir);
    int n;
    logic w;
    mem_txn(1'b1, 1'b0, to_ir, d, 1, 1'b0, n, w);
  endtask

  // Copies an X source through the ALU (pass X) into MAR so it shows on mem_addr.
  task automatic peek(input logic [5:0] t, output logic [15:0] v);
    cyc(LD_MAR, t, 3'd6);
    v = m.mem_addr;
  endtask

  // Reads each flag through status by loading IR with every select, no inversion.
  task automatic get_flags(output logic [3:0] f);
    logic [1:0] s;
    for (int i = 0; i < 4; i++) begin
      s = 2'(i);
      rd_mem({1'b0, s, 13'd0}, 1'b1);
      f[i] = status;
    end
  endtask

  initial begin
    vecs[0]  = '{16'h0007, 16'h0005, 3'd1, 16'hFFFE, 4'b0010};
    vecs[1]  = '{16'hFFFF, 16'h0001, 3'd0, 16'h0000, 4'b0101};
    vecs[2]  = '{16'h7FFF, 16'h0001, 3'd0, 16'h8000, 4'b1010};
    vecs[3]  = '{16'h0001, 16'h8000, 3'd1, 16'h7FFF, 4'b1100};
    vecs[4]  = '{16'hF0F0, 16'hFF00, 3'd2, 16'hF000, 4'b0010};
    vecs[5]  = '{16'hF0F0, 16'h0F0F, 3'd3, 16'hFFFF, 4'b0010};
    vecs[6]  = '{16'hAAAA, 16'hAAAA, 3'd4, 16'h0000, 4'b0001};
    vecs[7]  = '{16'hFFFF, 16'h1234, 3'd5, 16'h0000, 4'b0001};
    vecs[8]  = '{16'h8001, 16'h0000, 3'd6, 16'h8001, 4'b0010};
    vecs[9]  = '{16'hFFFF, 16'h0000, 3'd7, 16'h0000, 4'b0101};
    vecs[10] = '{16'h7FFF, 16'h0000, 3'd7, 16'h8000, 4'b1010};
    vecs[11] = '{16'h0005, 16'h0005, 3'd1, 16'h0000, 4'b0101};

    reset = 1'b1; ld = '0; tr = '0; alop = '0;
    mem_rd = 1'b0; mem_wr = 1'b0; rd_to_ir = 1'b0;
    m.mem_ack = 1'b0; m.mem_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Reset state.
    chk("rst_req", m.mem_req, 1'b0);
    chk("rst_we", m.mem_we, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_mar", m.mem_addr, 16'h0000);
    chk("rst_mdr", m.mem_wdata, 16'h0000);
    chk("rst_ir", instr, 16'h0000);
    chk("rst_status", status, 1'b0);
    chk("rst_sticky", {sp_fault, mem_err}, 2'b00);

    // Minimum transaction into IR, then label sign-extension into PC.
    mem_txn(1'b1, 1'b0, 1'b1, 16'h0FFE, 1, 1'b0, nb, we_seen);
    chk("min_busy_cycles", nb, 1);
    chk("ir_load", instr, 16'h0FFE);
    cyc(LD_PC, TR_LBL, 3'd6);
    peek(TR_PC, val);
    chk("pc_label_sext", val, 16'hFFFE);
    peek(TR_SP, val);
    chk("sp_reset", val, 16'hFFFF);

    // Read to IR with late ack; loads attempted during busy must be ignored.
    rd_mem(16'h0040, 1'b1);
    cyc(LD_MAR, TR_LBL, 3'd6);
    chk("mar_set", m.mem_addr, 16'h0040);
    mem_txn(1'b1, 1'b0, 1'b1, 16'h8123, 4, 1'b1, nb, we_seen);
    chk("rd_busy_cycles", nb, 4);
    chk("rd_we", we_seen, 1'b0);
    chk("rd_ir", instr, 16'h8123);
    chk("busy_mar_frozen", m.mem_addr, 16'h0040);
    chk("busy_mdr_frozen", m.mem_wdata, 16'h0000);
    chk("busy_sp_fault", sp_fault, 1'b0);
    peek(TR_PC, val);
    chk("busy_pc_frozen", val, 16'hFFFE);

    // ALU table: T <- a, MDR <- b, then op with flag load.
    foreach (vecs[i]) begin
      rd_mem(vecs[i].t, 1'b0);
      cyc(LD_T, TR_MDR, 3'd0);
      rd_mem(vecs[i].x, 1'b0);
      cyc(LD_MAR | LD_F, TR_MDR, vecs[i].op);
      chk($sformatf("alu_z[%0d]", i), m.mem_addr, vecs[i].z);
      get_flags(fl);
      chk($sformatf("alu_flags[%0d]", i), fl, vecs[i].f);
    end
    // Inverted condition: last flags are V0 C1 N0 Z1.
    rd_mem(16'h3000, 1'b1);
    chk("status_n_inv", status, 1'b1);
    rd_mem(16'h1000, 1'b1);
    chk("status_z_inv", status, 1'b0);

    // GPR write/read by IR index, and OR of two X sources.
    rd_mem(16'h0035, 1'b1);
    cyc(LD_R, TR_LBL, 3'd6);
    rd_mem(16'h0038, 1'b1);
    peek(TR_R, val);
    chk("gpr3", val, 16'h0035);
    peek(TR_R | TR_LBL, val);
    chk("xbus_or", val, 16'h003D);
    rd_mem(16'h0050, 1'b1);
    peek(TR_R, val);
    chk("gpr5", val, 16'h0000);

    // SP window.
    rd_mem(16'hEFFF, 1'b0);
    cyc(LD_SP, TR_MDR, 3'd6);
    chk("sp_fault_set", sp_fault, 1'b1);
    peek(TR_SP, val);
    chk("sp_unchanged", val, 16'hFFFF);
    rd_mem(16'hF000, 1'b0);
    cyc(LD_SP, TR_MDR, 3'd6);
    peek(TR_SP, val);
    chk("sp_limit", val, 16'hF000);

    // Write with no ack: timeout.
    rd_mem(16'hBEEF, 1'b0);
    mem_txn(1'b0, 1'b1, 1'b0, 16'h0000, 0, 1'b0, nb, we_seen);
    chk("wr_we", we_seen, 1'b1);
    chk("timeout_cycles", nb, 16);
    chk("mem_err", mem_err, 1'b1);
    chk("timeout_mdr", m.mem_wdata, 16'hBEEF);

    // Ack while idle is ignored.
    m.mem_ack = 1'b1; m.mem_rdata = 16'h1111;
    @(negedge clk);
    m.mem_ack = 1'b0;
    chk("idle_ack_busy", busy, 1'b0);
    chk("idle_ack_mdr", m.mem_wdata, 16'hBEEF);

    // Read and write together: write wins, nothing loaded.
    mem_txn(1'b1, 1'b1, 1'b1, 16'h5555, 1, 1'b0, nb, we_seen);
    chk("rdwr_we", we_seen, 1'b1);
    chk("rdwr_ir", instr, 16'h0050);
    chk("rdwr_mdr", m.mem_wdata, 16'hBEEF);

    // Reset during request, with an ack in the same cycle.
    mem_rd = 1'b1;
    @(negedge clk);
    mem_rd = 1'b0;
    chk("pre_rst_busy", busy, 1'b1);
    reset = 1'b1;
    m.mem_ack = 1'b1; m.mem_rdata = 16'h7777;
    @(negedge clk);
    reset = 1'b0;
    m.mem_ack = 1'b0;
    chk("rst_req_drop", m.mem_req, 1'b0);
    chk("rst_busy_drop", busy, 1'b0);
    chk("rst_mdr_clear", m.mem_wdata, 16'h0000);
    chk("rst_sticky_clear", {sp_fault, mem_err}, 2'b00);
    chk("rst_ir_clear", instr, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
